// File: rtl/my_serial_adder.sv
// my_serial_adder: bit-serial (LSB-first) adder built around a single full-adder cell and a 1-bit carry register.
// One result bit is produced per clock. r/cout update only on the final edge of an operation.
// Optional feature: define MY_SERIAL_ADDER_SUB_EN to honour the captured sub bit.
// With sub=1 the bench computes a - b: b is inverted and the initial carry is forced to 1.
// WIDTH must be >= 1.
module my_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;      // operand A, shifted right one bit per RUN edge
  logic [WIDTH-1:0] b_q;      // conditioned operand B', shifted likewise
  logic [WIDTH-1:0] acc_q;    // partial result, bits enter at the MSB end
  logic [WIDTH-1:0] r_q;
  logic             c_q;      // running carry
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] b_in_s;
  logic             c_in_s;
  logic             sum_s;
  logic             carry_s;
  logic [WIDTH:0]   acc_ext_s;
  logic [WIDTH-1:0] acc_d;

  // Majority of three bits: the carry-out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

`ifdef MY_SERIAL_ADDER_SUB_EN
  // Operand conditioning: subtract inverts B and forces the initial carry to 1 (two's complement).
  always_comb begin
    b_in_s = b;
    c_in_s = cin;
    if (sub) begin
      b_in_s = ~b;
      c_in_s = 1'b1;
    end else begin
      b_in_s = b;
      c_in_s = cin;
    end
  end
`else
  // The sub input is kept on the port list but has no effect in this build.
  logic unused_sub_s;
  assign unused_sub_s = sub;
  assign b_in_s       = b;
  assign c_in_s       = cin;
`endif

  // The single full-adder cell working on the current LSBs.
  assign sum_s     = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_s   = maj3(a_q[0], b_q[0], c_q);
  assign acc_ext_s = {sum_s, acc_q};
  assign acc_d     = acc_ext_s[WIDTH:1];

  // Control FSM and datapath state; r/cout load only on the last RUN edge, so no partial result is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_in_s;
            c_q     <= c_in_s;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1'b1;
          b_q   <= b_q >> 1'b1;
          c_q   <= carry_s;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            r_q     <= acc_d;
            cout_q  <= carry_s;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign r    = r_q;
  assign cout = cout_q;

endmodule

// File: doc/my_serial_adder.md
MY_SERIAL_ADDER -- requirements
Module: my_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 sub  input  1  subtract mode select; captured on the accepting edge; honoured only per REQ-030.
REQ-009 busy  output  1  high while an operation is in progress (state RUN).
REQ-010 done  output  1  single-cycle pulse: r and cout are valid.
REQ-011 r  output  WIDTH  sum/difference result; registered.
REQ-012 cout  output  1  final carry-out; registered.

Function
REQ-013 SHALL compute one result bit per clock with a single full-adder cell and a 1-bit carry register (bit-serial, LSB first).
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: start=1 -> capture a, b, cin, sub; clear bit counter; go to RUN.
REQ-016 IDLE: start=0 -> remain in IDLE.
REQ-017 RUN: each edge SHALL compute bit i = a[i] ^ b'[i] ^ c, update c = majority(a[i], b'[i], c), store bit i, increment counter.
REQ-018 RUN: the edge that processes bit WIDTH-1 SHALL load r with the full result and cout with the final carry, and go to DONE.
REQ-019 Latency: start accepted at edge k -> done=1 in the cycle following edge k+WIDTH.
REQ-020 DONE: done=1 for exactly one cycle; the next edge goes to RUN if start=1 (back-to-back, operands captured), else to IDLE.
REQ-021 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be state-decoded, with no combinational path from inputs.
REQ-022 start while in RUN SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-023 a, b, cin and sub SHALL be don't-care outside the accepting edge.
REQ-024 r and cout SHALL hold their last result from DONE until the next operation's final edge; intermediate bits SHALL NOT be visible on r.
REQ-025 Bit counter width SHALL be clog2(WIDTH+1); with WIDTH=1, RUN SHALL last exactly one cycle.
REQ-026 Add mode result: {cout, r} = a + b + cin, modulo 2^(WIDTH+1).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, r=0, cout=0, and clear the carry and counter, independent of clk.
REQ-028 Reset asserted in RUN SHALL abort the operation; done SHALL NOT pulse for it.
REQ-029 After rst_n rises, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-030 Macro MY_SERIAL_ADDER_SUB_EN defined: when the captured sub=1, b'=~b and the initial carry = 1 (cin ignored), giving r = a - b mod 2^WIDTH and cout = 1 when no borrow (a >= b unsigned).
REQ-031 Macro MY_SERIAL_ADDER_SUB_EN undefined: sub SHALL be ignored, b'=b, the initial carry = cin, and the port SHALL remain present.

Verification
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0, start pulse -> done exactly 8 cycles after the accepting edge, r=0x00, cout=1, busy high for 8 cycles.
REQ-033 WIDTH=8, a=0xA5, b=0x5A, cin=1 -> r=0x00, cout=1; then back-to-back start in the DONE cycle with a=0x03, b=0x04, cin=0 -> r=0x07, cout=0 eight cycles later.
REQ-034 WIDTH=8, start held high with new operands during RUN -> result unchanged (reflects first operands); exactly one done per accepted start.
REQ-035 WIDTH=8, rst_n pulsed low at cycle 4 of RUN -> outputs zero asynchronously, no done pulse; next operation 0x10+0x20 -> r=0x30, cout=0.
REQ-036 WIDTH=1, all 8 combinations of cin/a/b -> {cout, r} matches the full-adder truth table, with done 1 cycle after each accepting edge.
REQ-037 With MY_SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> r=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> r=0x02, cout=1. Without it: same stimulus gives add results (0x0C, cout=0).
